block_map_controller: RTL and testbench

- Owns the brick tile map: which 32x32 cells of the playfield contain a brick.
- Each cycle, translates the VGA pixel coordinate into a tile lookup and drives objectExists plus in-tile offsets to the brick bitmap renderer.
- Shares the single-port map RAM between the display reader and a game-logic writer that adds or removes bricks.
- Sits between the VGA sync/pixel counter and the brick bitmap.

---
 rtl/block_map_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_block_map_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_controller.sv
`default_nettype none
// ============================================================================
// Module      : block_map_controller
// Description : Brick tile map owner. The map is a MAP_COLS x MAP_ROWS grid of
//               1-bit cells, one per 32x32 tile. The map is stored in a
//               single-port RAM.
//               Every cycle, the VGA pixel coordinate is turned into a tile
//               lookup. The block drives objectExists and the in-tile offsets
//               to the brick bitmap renderer.
//               A game-logic writer shares the RAM port. It only gets the port
//               while the pixel is outside the map, so display always wins.
//               After reset, an INIT pass writes the default map: the bottom
//               row and both side columns hold bricks.
//
// Ports       : clk           system clock
//               resetN        synchronous reset, active HIGH despite the name
//               pixelX/Y      current VGA pixel column / row
//               wrReq         write request, held until wrAck
//               wrCol/Row     target tile of the write
//               wrData        1 = place brick, 0 = remove brick
//               wrAck         one-cycle pulse, write committed
//               initBusy      high while the default map is being written
//               objectExists  pixel (one cycle earlier) lies in a brick tile
//               offsetX/Y     pixel position inside its tile
//               qReq/qCol/qRow/qAck/qHit  tile query port (BLOCK_QUERY_EN)
//
// Options     : `define BLOCK_QUERY_EN adds the tile query port.
//
// Revision    : 1.0  initial release
// ============================================================================
module block_map_controller #(
    parameter int TILE_BITS = 5,
    parameter int MAP_COLS  = 20,
    parameter int MAP_ROWS  = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        wrReq,
    input  logic [4:0]  wrCol,
    input  logic [3:0]  wrRow,
    input  logic        wrData,
    output logic        wrAck,
    output logic        initBusy,
    output logic        objectExists,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY
`ifdef BLOCK_QUERY_EN
    ,
    input  logic        qReq,
    input  logic [4:0]  qCol,
    input  logic [3:0]  qRow,
    output logic        qAck,
    output logic        qHit
`endif
);

    localparam int              c_DEPTH   = MAP_COLS * MAP_ROWS;
    localparam int              c_ADDR_W  = $clog2(c_DEPTH);
    localparam logic [10:0]     c_X_LIMIT = 11'(MAP_COLS << TILE_BITS);
    localparam logic [10:0]     c_Y_LIMIT = 11'(MAP_ROWS << TILE_BITS);
    localparam logic [4:0]      c_COLS    = 5'(MAP_COLS);
    localparam logic [3:0]      c_ROWS    = 4'(MAP_ROWS);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [c_ADDR_W-1:0] tile_addr(input logic [4:0] col,
                                                      input logic [3:0] row);
        return c_ADDR_W'(int'(row) * MAP_COLS + int'(col));
    endfunction

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;

    logic [c_ADDR_W-1:0]   r_init_addr;
    logic [4:0]            r_init_col;
    logic [3:0]            r_init_row;
    logic                  w_init_last;
    logic                  w_init_bit;

    logic                  r_mem [c_DEPTH];
    logic                  r_rd_bit;
    logic                  w_mem_we;
    logic [c_ADDR_W-1:0]   w_mem_addr;
    logic                  w_mem_wdata;

    logic                  w_in_map;
    logic [4:0]            w_pix_col;
    logic [3:0]            w_pix_row;
    logic                  w_disp_en;
    logic                  w_wr_grant;
    logic                  w_wr_in_range;

    logic                  r_disp_valid;
    logic [10:0]           r_offset_x;
    logic [10:0]           r_offset_y;
    logic                  r_wr_ack;

`ifdef BLOCK_QUERY_EN
    logic                  w_q_grant;
    logic                  w_q_in_range;
    logic                  r_q_ack;
    logic                  r_q_in_range;
    logic                  r_q_hit_hold;
    logic                  w_q_hit;
`endif

    // ------------------------------------------------------------------
    // Pixel to tile translation
    // ------------------------------------------------------------------
    assign w_in_map  = (pixelX < c_X_LIMIT) && (pixelY < c_Y_LIMIT);
    assign w_pix_col = 5'(pixelX >> TILE_BITS);
    assign w_pix_row = 4'(pixelY >> TILE_BITS);

    assign w_wr_in_range = (wrCol < c_COLS) && (wrRow < c_ROWS);
`ifdef BLOCK_QUERY_EN
    assign w_q_in_range  = (qCol < c_COLS) && (qRow < c_ROWS);
`endif

    // ------------------------------------------------------------------
    // Default-map pattern for the INIT pass.
    // Column and row counters walk alongside the linear address, so no
    // divider is needed.
    // ------------------------------------------------------------------
    assign w_init_last = (r_init_addr == c_LAST_ADDR);
    assign w_init_bit  = (r_init_row == c_ROWS - 4'd1) ||
                         (r_init_col == 5'd0) ||
                         (r_init_col == c_COLS - 5'd1);

    // ------------------------------------------------------------------
    // FSM state register and INIT address counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
            r_init_col  <= '0;
            r_init_row  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                if (w_init_last) begin
                    r_init_addr <= '0;
                    r_init_col  <= '0;
                    r_init_row  <= '0;
                end else begin
                    r_init_addr <= r_init_addr + c_ADDR_W'(1);
                    if (r_init_col == c_COLS - 5'd1) begin
                        r_init_col <= '0;
                        r_init_row <= r_init_row + 4'd1;
                    end else begin
                        r_init_col <= r_init_col + 5'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and RAM port arbitration.
    // Priority in RUN is: display (in-map), then write, then query.
    // Blocking a re-grant while the ack is high prevents a held request
    // from being committed twice.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_disp_en    = 1'b0;
        w_wr_grant   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_init_addr;
        w_mem_wdata  = w_init_bit;
`ifdef BLOCK_QUERY_EN
        w_q_grant    = 1'b0;
`endif
        case (r_state)
            ST_INIT: begin
                w_mem_we = 1'b1;
                if (w_init_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_map) begin
                    w_disp_en  = 1'b1;
                    w_mem_addr = tile_addr(w_pix_col, w_pix_row);
                end else if (wrReq && !r_wr_ack) begin
                    w_wr_grant  = 1'b1;
                    // Out-of-range targets are acknowledged but never written.
                    w_mem_we    = w_wr_in_range;
                    w_mem_addr  = w_wr_in_range ? tile_addr(wrCol, wrRow) : '0;
                    w_mem_wdata = wrData;
                end
`ifdef BLOCK_QUERY_EN
                else if (qReq && !r_q_ack) begin
                    w_q_grant  = 1'b1;
                    w_mem_addr = w_q_in_range ? tile_addr(qCol, qRow) : '0;
                end
`endif
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-port map RAM with registered read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        r_rd_bit <= r_mem[w_mem_addr];
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_disp_valid <= 1'b0;
            r_offset_x   <= '0;
            r_offset_y   <= '0;
            r_wr_ack     <= 1'b0;
        end else begin
            r_disp_valid <= w_disp_en;
            r_offset_x   <= w_disp_en ? {{(11-TILE_BITS){1'b0}}, pixelX[TILE_BITS-1:0]} : '0;
            r_offset_y   <= w_disp_en ? {{(11-TILE_BITS){1'b0}}, pixelY[TILE_BITS-1:0]} : '0;
            r_wr_ack     <= w_wr_grant;
        end
    end

    // The read bit is only meaningful in the cycle after a display lookup.
    assign objectExists = r_disp_valid & r_rd_bit;
    assign offsetX      = r_offset_x;
    assign offsetY      = r_offset_y;
    assign wrAck        = r_wr_ack;
    assign initBusy     = (r_state == ST_INIT);

`ifdef BLOCK_QUERY_EN
    // ------------------------------------------------------------------
    // Query result. The fresh RAM bit is used in the ack cycle. Outside
    // the ack cycle, the last answer is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_q_ack      <= 1'b0;
            r_q_in_range <= 1'b0;
            r_q_hit_hold <= 1'b0;
        end else begin
            r_q_ack <= w_q_grant;
            if (w_q_grant) begin
                r_q_in_range <= w_q_in_range;
            end
            if (r_q_ack) begin
                r_q_hit_hold <= w_q_hit;
            end
        end
    end

    assign w_q_hit = r_q_ack ? (r_rd_bit & r_q_in_range) : r_q_hit_hold;
    assign qAck    = r_q_ack;
    assign qHit    = w_q_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_map_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_map_controller
// Description : Self-checking bench for block_map_controller. The bench keeps
//               a tile-map reference model (a 2-D array updated by the
//               display, arbitration and reset rules). Directed and $urandom
//               stimulus are compared against it every cycle.
//               Define BLOCK_QUERY_EN to exercise the query port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_block_map_controller;

    localparam int TILE   = 32;
    localparam int COLS   = 20;
    localparam int ROWS   = 15;
    localparam int XLIM   = COLS * TILE;
    localparam int YLIM   = ROWS * TILE;
    localparam int NCELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    logic        wr_req = 1'b0;
    logic [4:0]  wr_col = '0;
    logic [3:0]  wr_row = '0;
    logic        wr_data = 1'b0;
    logic        wrAck;
    logic        initBusy;
    logic        objectExists;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
`ifdef BLOCK_QUERY_EN
    logic        q_req = 1'b0;
    logic [4:0]  q_col = '0;
    logic [3:0]  q_row = '0;
    logic        qAck;
    logic        qHit;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_map [ROWS][COLS];
    int          m_init_left = 0;
    bit          e_obj = 0;
    int          e_ox = 0;
    int          e_oy = 0;
    bit          e_ack = 0;
`ifdef BLOCK_QUERY_EN
    bit          e_qack = 0;
    bit          e_qhit = 0;
`endif

    block_map_controller dut (
        .clk          (clk),
        .resetN       (rst),
        .pixelX       (px),
        .pixelY       (py),
        .wrReq        (wr_req),
        .wrCol        (wr_col),
        .wrRow        (wr_row),
        .wrData       (wr_data),
        .wrAck        (wrAck),
        .initBusy     (initBusy),
        .objectExists (objectExists),
        .offsetX      (offsetX),
        .offsetY      (offsetY)
`ifdef BLOCK_QUERY_EN
        ,
        .qReq         (q_req),
        .qCol         (q_col),
        .qRow         (q_row),
        .qAck         (qAck),
        .qHit         (qHit)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Default map: bottom row and both side columns are bricks.
    task automatic load_default();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_map[r][c] = (r == ROWS-1) || (c == 0) || (c == COLS-1);
    endtask

    // Advance the model by one clock, using the inputs applied this cycle.
    task automatic model_edge();
        bit in_map;
        bit grant;
`ifdef BLOCK_QUERY_EN
        bit qgrant;
`endif
        if (rst) begin
            load_default();
            m_init_left = NCELLS;
            e_obj = 0; e_ox = 0; e_oy = 0; e_ack = 0;
`ifdef BLOCK_QUERY_EN
            e_qack = 0; e_qhit = 0;
`endif
        end else if (m_init_left > 0) begin
            m_init_left--;
            e_obj = 0; e_ox = 0; e_oy = 0; e_ack = 0;
`ifdef BLOCK_QUERY_EN
            e_qack = 0;
`endif
        end else begin
            in_map = (int'(px) < XLIM) && (int'(py) < YLIM);
            grant  = 0;
`ifdef BLOCK_QUERY_EN
            qgrant = 0;
`endif
            if (in_map) begin
                e_obj = m_map[int'(py) / TILE][int'(px) / TILE];
                e_ox  = int'(px) % TILE;
                e_oy  = int'(py) % TILE;
            end else begin
                e_obj = 0; e_ox = 0; e_oy = 0;
                grant = wr_req && !e_ack;
`ifdef BLOCK_QUERY_EN
                qgrant = q_req && !grant && !e_qack;
`endif
            end
            if (grant && int'(wr_col) < COLS && int'(wr_row) < ROWS)
                m_map[wr_row][wr_col] = wr_data;
`ifdef BLOCK_QUERY_EN
            if (qgrant)
                e_qhit = (int'(q_col) < COLS && int'(q_row) < ROWS) ? m_map[q_row][q_col] : 1'b0;
            e_qack = qgrant;
`endif
            e_ack = grant;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("initBusy", 32'(initBusy), 32'(m_init_left > 0));
        check_val("objectExists", 32'(objectExists), 32'(e_obj));
        check_val("offsetX", 32'(offsetX), 32'(e_ox));
        check_val("offsetY", 32'(offsetY), 32'(e_oy));
        check_val("wrAck", 32'(wrAck), 32'(e_ack));
`ifdef BLOCK_QUERY_EN
        check_val("qAck", 32'(qAck), 32'(e_qack));
        check_val("qHit", 32'(qHit), 32'(e_qhit));
`endif
    endtask

    task automatic set_pixel(input int x, input int y);
        px = 11'(x);
        py = 11'(y);
    endtask

    task automatic rand_pixel();
        case ($urandom_range(0, 3))
            0, 1:    set_pixel(int'($urandom_range(0, XLIM-1)), int'($urandom_range(0, YLIM-1)));
            2:       set_pixel(int'($urandom_range(XLIM, 799)), int'($urandom_range(0, 524)));
            default: set_pixel(int'($urandom_range(0, 799)), int'($urandom_range(YLIM, 524)));
        endcase
    endtask

    task automatic set_write(input int c, input int r, input bit d);
        wr_req  = 1'b1;
        wr_col  = 5'(c);
        wr_row  = 4'(r);
        wr_data = d;
    endtask

    task automatic frame_scan();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                set_pixel(c*TILE + int'($urandom_range(0, TILE-1)),
                          r*TILE + int'($urandom_range(0, TILE-1)));
                tick();
            end
    endtask

    initial begin
        // Reset, then the full INIT pass.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < NCELLS; i++) begin
            rand_pixel();
            tick();
        end

        // Directed lookups.
        set_pixel(0, 100);   tick();
        set_pixel(320, 100); tick();
        set_pixel(320, 470); tick();
        set_pixel(37, 70);   tick();
        set_pixel(700, 10);  tick();

        // A write held while in map must wait for blanking.
        set_write(10, 5, 1'b1);
        for (int i = 0; i < 50; i++) begin
            set_pixel(int'($urandom_range(0, XLIM-1)), int'($urandom_range(0, YLIM-1)));
            tick();
        end
        set_pixel(650, 10);
        tick();
        tick();
        wr_req = 1'b0;
        set_pixel(330, 170);
        tick();

        // An out-of-range write is acknowledged, but the map is unchanged.
        set_write(25, 3, 1'b1);
        set_pixel(700, 300);
        tick();
        tick();
        wr_req = 1'b0;
        frame_scan();

        // Random traffic, with one mid-RUN reset while a request is pending.
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 1500);
            rand_pixel();
            if (e_ack || !wr_req) begin
                if ($urandom_range(0, 2) == 0)
                    set_write(int'($urandom_range(0, 22)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                else
                    wr_req = 1'b0;
            end
`ifdef BLOCK_QUERY_EN
            if (e_qack || !q_req) begin
                q_req = 1'($urandom_range(0, 1));
                q_col = 5'($urandom_range(0, 22));
                q_row = 4'($urandom_range(0, 15));
            end
`endif
            tick();
        end
        rst = 1'b0;
        wr_req = 1'b0;
        frame_scan();

        // Reset at INIT address 150 with a write pending.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_write(4, 4, 1'b1);
        set_pixel(700, 500);
        for (int i = 0; i < 150; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NCELLS + 2; i++) begin
            if (e_ack) wr_req = 1'b0;
            tick();
        end
        wr_req = 1'b0;
        set_pixel(4*TILE + 3, 4*TILE + 9);
        tick();

`ifdef BLOCK_QUERY_EN
        // A write and a query in the same blanking cycle.
        q_req = 1'b0;
        set_pixel(660, 200);
        set_write(3, 3, 1'b1);
        q_req = 1'b1;
        q_col = 5'd0;
        q_row = 4'd14;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (e_qack) q_req = 1'b0;
            tick();
        end
        q_req = 1'b0;
        set_pixel(3*TILE, 3*TILE);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
